// File: rtl/spi_ahb_loader_if.sv
// rtl/spi_ahb_loader_if.sv - AHB-Lite write-master bus between the SPI loader and the memory router
interface spi_ahb_loader_if;
    logic [31:0] spi_haddr;
    logic        spi_hwrite;
    logic [2:0]  spi_hsize;
    logic [2:0]  spi_hburst;
    logic [3:0]  spi_hprot;
    logic        spi_hmastlock;
    logic [1:0]  spi_htrans;
    logic [31:0] spi_hwdata;
    logic        spi_hready;
    logic        spi_hresp;
    logic [31:0] spi_hrdata;

    modport master (
        output spi_haddr,
        output spi_hwrite,
        output spi_hsize,
        output spi_hburst,
        output spi_hprot,
        output spi_hmastlock,
        output spi_htrans,
        output spi_hwdata,
        input  spi_hready,
        input  spi_hresp,
        input  spi_hrdata
    );

    modport slave (
        input  spi_haddr,
        input  spi_hwrite,
        input  spi_hsize,
        input  spi_hburst,
        input  spi_hprot,
        input  spi_hmastlock,
        input  spi_htrans,
        input  spi_hwdata,
        output spi_hready,
        output spi_hresp,
        output spi_hrdata
    );
endinterface

// File: rtl/spi_ahb_loader.sv
// rtl/spi_ahb_loader.sv - SPI-slave program loader driving single AHB-Lite NONSEQ word writes
module spi_ahb_loader #(
    parameter logic [7:0] WRITE_CMD   = 8'h01,
    parameter logic [7:0] RUN_CMD     = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    spi_ahb_loader_if.master  bus,
    output logic              SPI_change,
    output logic              load_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [6:0] FRAME_BITS    = 7'd72;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic                   sclk_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic rise;
    logic fall;

    // Frame receive state
    logic [6:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [62:0] word_sr;
    logic [7:0]  echo_q;
    logic [7:0]  cmd_q;
    logic        miso_q;

    // Pending word and bus-side state
    state_t      state;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    logic        run_pend;
    logic [1:0]  htrans_q;
    logic [31:0] haddr_q;
    logic [31:0] hwdata_q;

    logic        frames_off;
    logic [7:0]  byte_in;
    logic [63:0] full_word;
    logic        run_hit;
    logic        word_hit;
    logic        run_now;
    logic        can_release;
    logic        unused_hrdata;

    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];
    assign cs_s   = cs_sr[SYNC_STAGES-1];

    assign rise = sclk_s & ~sclk_q & ~cs_s;
    assign fall = ~sclk_s & sclk_q & ~cs_s;

    // Once the core owns the router (or a release is waiting), the SPI port goes deaf
    assign frames_off = SPI_change | run_pend;

    assign byte_in   = {shift_q, mosi_s};
    assign full_word = {word_sr, mosi_s};

    assign run_hit  = rise & ~frames_off & (bit_cnt == 7'd7) & (byte_in == RUN_CMD);
    assign word_hit = rise & ~frames_off & (bit_cnt == 7'd71) & (cmd_q == WRITE_CMD);
    assign run_now  = run_hit | run_pend;

    // Release is allowed from an empty IDLE, or on the edge that finishes the last write
    assign can_release = ((state == S_IDLE) && !pend) ||
                         ((state == S_DATA) && bus.spi_hready);

    assign spi_miso          = miso_q;
    assign bus.spi_haddr     = haddr_q;
    assign bus.spi_hwdata    = hwdata_q;
    assign bus.spi_htrans    = htrans_q;
    assign bus.spi_hwrite    = 1'b1;
    assign bus.spi_hsize     = 3'b010;
    assign bus.spi_hburst    = 3'b000;
    assign bus.spi_hprot     = 4'b0011;
    assign bus.spi_hmastlock = 1'b0;

    assign unused_hrdata = ^bus.spi_hrdata;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            cs_sr   <= '1;
            sclk_q  <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            sclk_q  <= sclk_s;
        end
    end

    // Frame receiver, pending-word hand-off, AHB write FSM and core release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            word_sr    <= '0;
            echo_q     <= '0;
            cmd_q      <= '0;
            miso_q     <= 1'b0;
            state      <= S_IDLE;
            pend       <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            run_pend   <= 1'b0;
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            SPI_change <= 1'b0;
            load_error <= 1'b0;
        end else begin
            if (cs_s) begin
                bit_cnt <= '0;
                shift_q <= '0;
                word_sr <= '0;
                echo_q  <= '0;
                cmd_q   <= '0;
                miso_q  <= 1'b0;
            end else if (!frames_off) begin
                if (rise && (bit_cnt < FRAME_BITS)) begin
                    shift_q <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 7'd1;
                    if (bit_cnt >= 7'd8) begin
                        word_sr <= {word_sr[61:0], mosi_s};
                    end
                    if (bit_cnt[2:0] == 3'd7) begin
                        echo_q <= byte_in;
                    end
                    if (bit_cnt == 7'd7) begin
                        cmd_q <= byte_in;
                    end
                end else if (fall) begin
                    miso_q <= echo_q[7];
                    echo_q <= {echo_q[6:0], 1'b0};
                end
            end

            case (state)
                S_IDLE: begin
                    if (pend && !SPI_change) begin
                        state    <= S_ADDR;
                        htrans_q <= HTRANS_NONSEQ;
                        haddr_q  <= pend_addr;
                    end
                end
                S_ADDR: begin
                    if (bus.spi_hready) begin
                        state    <= S_DATA;
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= pend_data;
                    end
                end
                S_DATA: begin
                    if (bus.spi_hready) begin
                        state <= S_IDLE;
                        pend  <= 1'b0;
                        if (bus.spi_hresp) begin
                            load_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    htrans_q <= HTRANS_IDLE;
                end
            endcase

            // A second word arriving while one is still held is lost, and flagged
            if (word_hit) begin
                if (pend) begin
                    load_error <= 1'b1;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= full_word[63:32];
                    pend_data <= full_word[31:0];
                end
            end

            if (run_now && !SPI_change) begin
                if (can_release) begin
                    SPI_change <= 1'b1;
                    run_pend   <= 1'b0;
                end else begin
                    run_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ahb_loader.sv
// tb/tb_spi_ahb_loader.sv - scoreboard bench for spi_ahb_loader
module tb_spi_ahb_loader;

    logic clk = 1'b0;
    logic reset;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    logic spi_change;
    logic load_error;

    spi_ahb_loader_if bus ();

    always #5 clk = ~clk;

    spi_ahb_loader dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (sclk),
        .spi_mosi   (mosi),
        .spi_cs_n   (cs_n),
        .spi_miso   (miso),
        .bus        (bus.master),
        .SPI_change (spi_change),
        .load_error (load_error)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          nonseq_cnt = 0;
    logic [63:0] sb_q[$];
    bit          in_data = 0;
    bit          addr_phase = 0;
    bit          unexpected = 0;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;

    // Bus monitor: pops the scoreboard on each NONSEQ and checks address/data phases
    always @(negedge clk) begin
        if (reset) begin
            in_data    = 0;
            addr_phase = 0;
        end else begin
            if (in_data) begin
                n_tests++;
                if (bus.spi_htrans !== 2'b00) begin
                    n_fail++;
                    $display("FAIL data_htrans got=%b exp=00", bus.spi_htrans);
                end
                if (!unexpected) begin
                    n_tests++;
                    if (bus.spi_hwdata !== cur_data) begin
                        n_fail++;
                        $display("FAIL hwdata got=%h exp=%h", bus.spi_hwdata, cur_data);
                    end
                end
                if (bus.spi_hready) in_data = 0;
            end
            if (bus.spi_htrans === 2'b10) begin
                if (!addr_phase) begin
                    addr_phase = 1;
                    nonseq_cnt++;
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        unexpected = 1;
                        n_fail++;
                        $display("FAIL unexpected_nonseq haddr=%h exp=none", bus.spi_haddr);
                    end else begin
                        unexpected = 0;
                        {cur_addr, cur_data} = sb_q.pop_front();
                    end
                end
                if (!unexpected) begin
                    n_tests++;
                    if (bus.spi_haddr !== cur_addr) begin
                        n_fail++;
                        $display("FAIL haddr got=%h exp=%h", bus.spi_haddr, cur_addr);
                    end
                end
                if (bus.spi_hready) begin
                    addr_phase = 0;
                    in_data    = 1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SPI mode-0 host: sclk = clk/16; records miso at the first 24 rises
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input int nbits,
                              output logic [23:0] echo);
        logic [71:0] f;
        f    = {cmd, addr, data};
        echo = '0;
        cs_n = 1'b0;
        cyc(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = f[71-i];
            cyc(8);
            sclk = 1'b1;
            if (i < 24) echo[23-i] = miso;
            cyc(8);
            sclk = 1'b0;
        end
        cyc(8);
        cs_n = 1'b1;
        mosi = 1'b0;
        cyc(8);
    endtask

    task automatic wait_nonseq(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.spi_htrans === 2'b10) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_nonseq_timeout got=none exp=NONSEQ", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !in_data && !addr_phase) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d exp=0", name, sb_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs_n  = 1'b1;
        bus.spi_hready = 1'b1;
        bus.spi_hresp  = 1'b0;
        bus.spi_hrdata = '0;
        cyc(3);
        n_tests++;
        if (bus.spi_htrans !== 2'b00 || bus.spi_haddr !== 32'h0 || bus.spi_hwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus got=%b/%h/%h exp=00/0/0", bus.spi_htrans, bus.spi_haddr, bus.spi_hwdata);
        end
        n_tests++;
        if (bus.spi_hwrite !== 1'b1 || bus.spi_hsize !== 3'b010 || bus.spi_hburst !== 3'b000 ||
            bus.spi_hprot !== 4'b0011 || bus.spi_hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_const got=%b/%b/%b/%b/%b exp=1/010/000/0011/0", bus.spi_hwrite,
                     bus.spi_hsize, bus.spi_hburst, bus.spi_hprot, bus.spi_hmastlock);
        end
        check_bit("reset_miso", miso, 1'b0);
        check_bit("reset_spi_change", spi_change, 1'b0);
        check_bit("reset_load_error", load_error, 1'b0);
        reset = 1'b0;
        cyc(4);
        check_bit("post_reset_htrans_idle", bus.spi_htrans[1], 1'b0);
    endtask

    task automatic test_single_write();
        logic [23:0] echo;
        int          n0;
        n0 = nonseq_cnt;
        sb_q.push_back({32'h0000_4010, 32'hDEAD_BEEF});
        send_frame(8'h01, 32'h0000_4010, 32'hDEAD_BEEF, 72, echo);
        wait_drain("single");
        n_tests++;
        if (nonseq_cnt - n0 != 1) begin
            n_fail++;
            $display("FAIL single_count got=%0d exp=1", nonseq_cnt - n0);
        end
        n_tests++;
        if (echo !== 24'h00_01_00) begin
            n_fail++;
            $display("FAIL single_echo got=%h exp=000100", echo);
        end
        check_bit("single_load_error", load_error, 1'b0);
    endtask

    task automatic test_wait_states();
        logic [23:0] echo;
        int          n0;
        n0 = nonseq_cnt;
        bus.spi_hready = 1'b0;
        sb_q.push_back({32'h0000_4010, 32'hDEAD_BEEF});
        send_frame(8'h01, 32'h0000_4010, 32'hDEAD_BEEF, 72, echo);
        wait_nonseq("wait");
        cyc(3);
        bus.spi_hready = 1'b1;
        cyc(1);
        bus.spi_hready = 1'b0;
        cyc(2);
        bus.spi_hready = 1'b1;
        wait_drain("wait");
        cyc(2);
        check_bit("wait_idle_after", bus.spi_htrans[1], 1'b0);
        n_tests++;
        if (nonseq_cnt - n0 != 1) begin
            n_fail++;
            $display("FAIL wait_count got=%0d exp=1", nonseq_cnt - n0);
        end
    endtask

    task automatic test_abort();
        logic [23:0] echo;
        int          n0;
        n0 = nonseq_cnt;
        send_frame(8'h01, 32'h0000_9999, 32'h1111_2222, 40, echo);
        sb_q.push_back({32'h0000_8004, 32'h0000_0055});
        send_frame(8'h01, 32'h0000_8004, 32'h0000_0055, 72, echo);
        wait_drain("abort");
        n_tests++;
        if (nonseq_cnt - n0 != 1) begin
            n_fail++;
            $display("FAIL abort_count got=%0d exp=1", nonseq_cnt - n0);
        end
    endtask

    task automatic test_ignore_cmd();
        logic [23:0] echo;
        int          n0;
        n0 = nonseq_cnt;
        send_frame(8'h5A, 32'h0000_1000, 32'h0BAD_F00D, 72, echo);
        cyc(20);
        n_tests++;
        if (nonseq_cnt != n0) begin
            n_fail++;
            $display("FAIL ignore_count got=%0d exp=0", nonseq_cnt - n0);
        end
        check_bit("ignore_load_error", load_error, 1'b0);
        check_bit("ignore_spi_change", spi_change, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] echo;
        int          n0;
        n0 = nonseq_cnt;
        sb_q.push_back({32'h2000_0100, 32'h0123_4567});
        sb_q.push_back({32'h2000_0104, 32'h89AB_CDEF});
        send_frame(8'h01, 32'h2000_0100, 32'h0123_4567, 72, echo);
        n_tests++;
        if (echo !== 24'h00_01_20) begin
            n_fail++;
            $display("FAIL b2b_echo got=%h exp=000120", echo);
        end
        send_frame(8'h01, 32'h2000_0104, 32'h89AB_CDEF, 72, echo);
        wait_drain("b2b");
        n_tests++;
        if (nonseq_cnt - n0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=2", nonseq_cnt - n0);
        end
        check_bit("b2b_load_error", load_error, 1'b0);
    endtask

    task automatic test_error_resp();
        logic [23:0] echo;
        check_bit("err_before", load_error, 1'b0);
        bus.spi_hready = 1'b0;
        sb_q.push_back({32'h0000_0040, 32'hCAFE_0001});
        send_frame(8'h01, 32'h0000_0040, 32'hCAFE_0001, 72, echo);
        wait_nonseq("err");
        bus.spi_hready = 1'b1;
        bus.spi_hresp  = 1'b1;
        cyc(2);
        bus.spi_hresp  = 1'b0;
        wait_drain("err");
        check_bit("err_set", load_error, 1'b1);
        sb_q.push_back({32'h0000_0044, 32'hCAFE_0002});
        send_frame(8'h01, 32'h0000_0044, 32'hCAFE_0002, 72, echo);
        wait_drain("err_good");
        check_bit("err_sticky", load_error, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [23:0] echo;
        bus.spi_hready = 1'b0;
        sb_q.push_back({32'h0000_0080, 32'h5555_AAAA});
        send_frame(8'h01, 32'h0000_0080, 32'h5555_AAAA, 72, echo);
        wait_nonseq("rstmid");
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.spi_htrans !== 2'b00 || bus.spi_haddr !== 32'h0 || bus.spi_hwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_bus got=%b/%h/%h exp=00/0/0", bus.spi_htrans, bus.spi_haddr, bus.spi_hwdata);
        end
        check_bit("rstmid_spi_change", spi_change, 1'b0);
        check_bit("rstmid_load_error", load_error, 1'b0);
        sb_q.delete();
        cyc(2);
        reset = 1'b0;
        bus.spi_hready = 1'b1;
        cyc(2);
        sb_q.push_back({32'h0000_00C0, 32'h7777_1234});
        send_frame(8'h01, 32'h0000_00C0, 32'h7777_1234, 72, echo);
        wait_drain("rstmid_after");
        check_bit("rstmid_after_err", load_error, 1'b0);
    endtask

    task automatic test_run_sequence();
        logic [23:0] echo;
        int          n0;
        bus.spi_hready = 1'b0;
        sb_q.push_back({32'h0000_0200, 32'h0000_00AA});
        send_frame(8'h01, 32'h0000_0200, 32'h0000_00AA, 72, echo);
        wait_nonseq("run");
        bus.spi_hready = 1'b1;
        cyc(1);
        bus.spi_hready = 1'b0;
        send_frame(8'hFF, 32'h0, 32'h0, 72, echo);
        check_bit("run_held_while_stalled", spi_change, 1'b0);
        check_bit("run_still_in_data", in_data, 1'b1);
        bus.spi_hready = 1'b1;
        cyc(1);
        check_bit("run_released", spi_change, 1'b1);
        wait_drain("run");
        n0 = nonseq_cnt;
        send_frame(8'h01, 32'h0000_0300, 32'h0000_00BB, 72, echo);
        cyc(20);
        n_tests++;
        if (nonseq_cnt != n0) begin
            n_fail++;
            $display("FAIL run_blocked got=%0d exp=0", nonseq_cnt - n0);
        end
        check_bit("run_stays", spi_change, 1'b1);
        check_bit("run_idle", bus.spi_htrans[1], 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wait_states();
        test_abort();
        test_ignore_cmd();
        test_back_to_back();
        test_error_resp();
        test_reset_mid();
        test_run_sequence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ahb_loader.md
# spi_ahb_loader

SPI-slave program loader and AHB-Lite write master that feeds the `spi_h*` port of the memory router. An external host shifts in framed write commands; each command becomes one 32-bit AHB NONSEQ write into instruction memory, data memory or registers. A final RUN command raises `SPI_change`, which hands the router over to the RISC-V core buses.

## Interface
- `WRITE_CMD`, default 8'h01: command byte for a word write.
- `RUN_CMD`, default 8'hFF: command byte that releases the core.
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sclk`, `spi_mosi`, `spi_cs_n`. Legal range is ≥2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `spi_sclk` in 1: SPI clock, mode 0, frequency ≤ clk/8.
- `spi_mosi` in 1: serial data in, MSB first.
- `spi_cs_n` in 1: active-low frame select.
- `spi_miso` out 1: serial echo out.
- `spi_haddr` out 32: AHB address.
- `spi_hwrite` out 1: always 1.
- `spi_hsize` out 3: always 3'b010.
- `spi_hburst` out 3: always 3'b000.
- `spi_hprot` out 4: always 4'b0011.
- `spi_hmastlock` out 1: always 0.
- `spi_htrans` out 2: IDLE 2'b00 or NONSEQ 2'b10.
- `spi_hwdata` out 32: AHB write data.
- `spi_hready` in 1: router ready.
- `spi_hresp` in 1: router response, 1 = ERROR.
- `spi_hrdata` in 32: unused; must be accepted without lint warnings.
- `SPI_change` out 1: 0 = loader owns the router, 1 = core owns it.
- `load_error` out 1: sticky error flag.

## Operation
- **Input sync.** `spi_sclk`, `spi_mosi` and `spi_cs_n` pass through `SYNC_STAGES` flops.
  - A rise is registered sync sclk 0 followed by 1 while sync `cs_n` = 0; a fall is the reverse.
- **Shifting.**
  - On a rise: shift `mosi` into an 8-bit shifter and increment a 7-bit bit counter.
  - On a fall: shift `spi_miso` out of an 8-bit echo register.
  - Each completed byte loads into the echo register, so the host sees the previous byte, one byte delayed.
  - The first byte of a frame echoes 8'h00.
- **Frame layout.** A frame is one cmd byte, then 4 address bytes, then 4 data bytes, all MSB first: 72 bits total.
  - When the cmd byte completes and equals `RUN_CMD`, `SPI_change` sets at once. Remaining bits are ignored.
  - When the cmd byte is neither `RUN_CMD` nor `WRITE_CMD`, the frame is ignored and no error is raised.
- **Frame abort.** Sync `cs_n` = 1 clears the bit counter and shifters; a partial frame is discarded.
- **Word hand-off.** On bit 72 of a WRITE frame, address and data latch into a pending holding register and `pend` sets.
  - If `pend` is already set, the new frame is dropped and `load_error` sets.
- **AHB FSM.** States are IDLE, ADDR and DATA; reset state is IDLE.
  - IDLE → ADDR when `pend` = 1 and `SPI_change` = 0. In ADDR: `spi_htrans` = NONSEQ and `spi_haddr` = held address.
  - ADDR → DATA on `spi_hready` = 1. In DATA: `spi_htrans` = IDLE and `spi_hwdata` = held data.
  - DATA → IDLE on `spi_hready` = 1. This clears `pend`.
  - `spi_hresp` = 1 sampled with `spi_hready` in DATA sets `load_error`; the word is not retried.
- **Run.** Once `SPI_change` = 1:
  - No new transfer starts, and SPI frames are ignored until reset.
  - A transfer already in ADDR or DATA completes before the FSM parks in IDLE.
  - `SPI_change` does not rise before `pend` is clear. If RUN arrives while `pend` = 1, it takes effect the cycle the FSM returns to IDLE.
- **Reset values.** Reset asserted at any time forces the following immediately, aborting any in-flight transfer:
  - `SPI_change` = 0, `load_error` = 0, `spi_htrans` = 2'b00, `spi_haddr` = 0, `spi_hwdata` = 0, `spi_miso` = 0.
  - FSM = IDLE, `pend` = 0, counters cleared.

## Timing
- Sync-to-detect latency is SYNC_STAGES + 1 clk cycles after the pin edge.
- Let E be the clk cycle in which the bit-72 rise is detected. Then:
  - E+1: `pend` = 1.
  - E+2: ADDR (NONSEQ) is driven.
  - With `spi_hready` held at 1, E+3 is DATA and E+4 is IDLE.
- `spi_haddr` is stable through all ADDR cycles; `spi_hwdata` is stable through all DATA cycles.
- Back-to-back frames never overflow at sclk ≤ clk/8: a frame spans ≥576 clk cycles, and a write finishes in 3 cycles with zero wait states.
- `SPI_change` is registered and glitch-free. It changes only in IDLE.

## Test plan
- **Single write.** Frame 01 00004010 DEADBEEF with hready = 1 → exactly one NONSEQ at haddr 0x00004010, hwdata 0xDEADBEEF on the next cycle, `load_error` = 0.
- **Wait states.** Same frame with hready held 0 for 3 cycles in ADDR and 2 in DATA → haddr and hwdata held steady, one transfer, then IDLE.
- **Abort.** `cs_n` deasserted after 40 bits, then a full frame 01 00008004 00000055 → only 0x00008004 / 0x00000055 is written.
- **Error response.** hresp = 1 in DATA → `load_error` = 1 and stays 1 through later good writes until reset.
- **RUN sequence.** RUN frame (FF) while a write is stalled in DATA → `SPI_change` rises only after that write completes. No further htrans NONSEQ for a subsequent write frame.
- **Reset mid-transfer.** Reset asserted during ADDR → htrans = 00 in the same cycle, `SPI_change` = 0, `load_error` = 0; a new frame after reset writes normally.
